execute_muldiv: RTL and testbench

Parametrised multi-cycle multiply/divide unit in the EX stage, beside the single-cycle ALU path. Resolves forwarded operands with the same fwd_A/fwd_B encoding as the ALU operands, captures them, then runs an iterative shift-add multiplier or restoring divider. It asserts `busy` to stall the pipeline and pulses `done` with a registered result for EX/MEM.

---
 rtl/execute_muldiv.sv | 145 ++++++++++++++
 tb/tb_execute_muldiv.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/execute_muldiv.sv
// EX-stage multi-cycle unsigned multiply/divide unit: shift-add multiplier and
// restoring divider sharing one 2*WIDTH accumulator, stalling the pipe via busy.
module execute_muldiv #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] ReadDataA,
  input  logic [WIDTH-1:0] ReadDataB,
  input  logic [WIDTH-1:0] data_exmem,
  input  logic [WIDTH-1:0] data_memwb,
  input  logic [1:0]       fwd_A,
  input  logic [1:0]       fwd_B,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             DivZero,
  output logic             err
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nx;
  logic               w_busy;
  logic [1:0]         r_op;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_b;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_result;
  logic               r_divzero;

  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic               w_capture;
  logic               w_dz_cap;
  logic               w_last;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH-1:0]   w_diff;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_mul_nx;
  logic [2*WIDTH-1:0] w_div_nx;
  logic [WIDTH-1:0]   w_res_nx;

  // bit1 of the forwarding select outranks bit0
  assign w_a = fwd_A[1] ? data_exmem : (fwd_A[0] ? data_memwb : ReadDataA);
  assign w_b = fwd_B[1] ? data_exmem : (fwd_B[0] ? data_memwb : ReadDataB);

  assign w_capture = (r_state == S_IDLE) && start && !flush;
  assign w_dz_cap  = op[1] && (w_b == '0);
  assign w_last    = (r_cnt == CW'(1));

  // Multiply: acc = {hi, lo}; conditional add into hi with carry, then shift right.
  assign w_addend = r_acc[0] ? r_b : {WIDTH{1'b0}};
  assign w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
  assign w_mul_nx = {w_sum, r_acc[WIDTH-1:1]};

  // Divide: acc = {rem, quo}; the shifted remainder needs WIDTH+1 bits to compare.
  assign w_rem_sh = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_ge     = (w_rem_sh >= {1'b0, r_b});
  assign w_diff   = w_rem_sh[WIDTH-1:0] - r_b;
  assign w_div_nx = {(w_ge ? w_diff : w_rem_sh[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};

  always_comb begin
    w_res_nx = w_mul_nx[WIDTH-1:0];
    case (r_op)
      2'b00:   w_res_nx = w_mul_nx[WIDTH-1:0];
      2'b01:   w_res_nx = w_mul_nx[2*WIDTH-1:WIDTH];
      2'b10:   w_res_nx = w_div_nx[WIDTH-1:0];
      default: w_res_nx = w_div_nx[2*WIDTH-1:WIDTH];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_busy     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !flush) begin
          w_busy     = 1'b1;
          w_state_nx = w_dz_cap ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        w_busy = 1'b1;
        if (flush) begin
          w_state_nx = S_IDLE;
        end else if (w_last) begin
          w_state_nx = S_DONE;
        end
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op      <= '0;
      r_acc     <= '0;
      r_b       <= '0;
      r_cnt     <= '0;
      r_result  <= '0;
      r_divzero <= 1'b0;
    end else if (w_capture) begin
      r_op  <= op;
      r_b   <= w_b;
      r_acc <= {{WIDTH{1'b0}}, w_a};
      r_cnt <= CW'(WIDTH);
      if (w_dz_cap) begin
        r_result  <= op[0] ? w_a : {WIDTH{1'b1}};
        r_divzero <= 1'b1;
      end
    end else if ((r_state == S_CALC) && !flush) begin
      r_acc <= r_op[1] ? w_div_nx : w_mul_nx;
      r_cnt <= r_cnt - 1'b1;
      if (w_last) begin
        r_result  <= w_res_nx;
        r_divzero <= 1'b0;
      end
    end
  end

  assign busy    = w_busy;
  assign done    = (r_state == S_DONE);
  assign Result  = r_result;
  assign DivZero = r_divzero;
  assign err     = done && r_divzero;

endmodule

// File: tb/tb_execute_muldiv.sv
// Scoreboard bench for execute_muldiv: expected results queued at issue,
// popped and compared whenever done is seen.
module tb_execute_muldiv;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [1:0]   op = '0;
  logic [1:0]   fwd_A = '0;
  logic [1:0]   fwd_B = '0;
  logic [W-1:0] ReadDataA = '0;
  logic [W-1:0] ReadDataB = '0;
  logic [W-1:0] data_exmem = '0;
  logic [W-1:0] data_memwb = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] Result;
  logic         DivZero;
  logic         err;

  typedef struct {
    logic [W-1:0] res;
    logic         dz;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           failures = 0;
  logic [W-1:0] last_res = '0;

  execute_muldiv #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .ReadDataA  (ReadDataA),
    .ReadDataB  (ReadDataB),
    .data_exmem (data_exmem),
    .data_memwb (data_memwb),
    .fwd_A      (fwd_A),
    .fwd_B      (fwd_B),
    .flush      (flush),
    .busy       (busy),
    .done       (done),
    .Result     (Result),
    .DivZero    (DivZero),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", 32'(Result), 32'(e.res));
        chk("divzero", 32'(DivZero), 32'(e.dz));
        chk("err", 32'(err), 32'(e.dz));
        last_res = e.res;
      end
    end
  end

  task automatic do_op(input logic [1:0] o, input logic [W-1:0] ra, input logic [W-1:0] rb,
                       input logic [1:0] fa, input logic [1:0] fb,
                       input logic [W-1:0] ex, input logic [W-1:0] mw, input bit perturb);
    logic [W-1:0]   ea, eb;
    logic [2*W-1:0] p;
    exp_t           e;
    int             lat, n;
    ea = fa[1] ? ex : (fa[0] ? mw : ra);
    eb = fb[1] ? ex : (fb[0] ? mw : rb);
    p  = {{W{1'b0}}, ea} * {{W{1'b0}}, eb};
    e.dz = o[1] && (eb == '0);
    case (o)
      2'b00:   e.res = p[W-1:0];
      2'b01:   e.res = p[2*W-1:W];
      2'b10:   e.res = (eb == '0) ? {W{1'b1}} : ea / eb;
      default: e.res = (eb == '0) ? ea : ea % eb;
    endcase
    lat = e.dz ? 1 : W + 1;
    @(negedge clk);
    op = o; ReadDataA = ra; ReadDataB = rb; fwd_A = fa; fwd_B = fb;
    data_exmem = ex; data_memwb = mw; start = 1'b1;
    sb.push_back(e);
    #1 chk("busy_c0", 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
      if (perturb && n == 3) begin
        ReadDataA = W'($urandom); ReadDataB = W'($urandom);
        data_exmem = W'($urandom); data_memwb = W'($urandom);
      end
      if (!done) chk("busy_calc", 32'(busy), 32'd1);
    end
    chk("latency", 32'(n), 32'(lat));
    chk("busy_done", 32'(busy), 32'd0);
    start = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(Result), 32'd0);
    chk("rst_divzero", 32'(DivZero), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    #1 chk("rst_busy_idle", 32'(busy), 32'd0);
    start = 1'b1;
    #1 chk("rst_busy_start", 32'(busy), 32'd1);
    start = 1'b0;

    do_op(2'b00, 16'h0003, 16'h0005, 2'b00, 2'b00, '0, '0, 1'b0);
    do_op(2'b00, 16'hFFFF, 16'hFFFF, 2'b00, 2'b00, '0, '0, 1'b0);
    do_op(2'b01, 16'hFFFF, 16'hFFFF, 2'b00, 2'b00, '0, '0, 1'b0);
    do_op(2'b01, 16'h8000, 16'h0002, 2'b00, 2'b00, '0, '0, 1'b0);
    do_op(2'b10, 16'd100, 16'd7, 2'b00, 2'b00, '0, '0, 1'b0);
    do_op(2'b11, 16'd100, 16'd7, 2'b00, 2'b00, '0, '0, 1'b0);
    do_op(2'b10, 16'd5, 16'd9, 2'b00, 2'b00, '0, '0, 1'b0);
    do_op(2'b11, 16'd5, 16'd9, 2'b00, 2'b00, '0, '0, 1'b0);
    do_op(2'b10, 16'h1234, 16'h0000, 2'b00, 2'b00, '0, '0, 1'b0);
    do_op(2'b11, 16'h1234, 16'h0000, 2'b00, 2'b00, '0, '0, 1'b0);
    do_op(2'b10, 16'hFFFF, 16'h8001, 2'b00, 2'b00, '0, '0, 1'b0);
    do_op(2'b11, 16'hFFFF, 16'h8001, 2'b00, 2'b00, '0, '0, 1'b0);
    do_op(2'b00, 16'h0000, 16'h0000, 2'b10, 2'b01, 16'd6, 16'd7, 1'b1);
    do_op(2'b00, 16'h0001, 16'h0002, 2'b11, 2'b11, 16'd6, 16'd9, 1'b1);
    do_op(2'b10, 16'h0000, 16'h0000, 2'b01, 2'b00, 16'd3, 16'd0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      do_op(2'($urandom_range(0, 3)), W'($urandom), W'($urandom_range(1, 16'hFFFF)),
            2'($urandom_range(0, 3)), 2'b00, W'($urandom), W'($urandom), 1'b0);
    end

    // flush mid-DIV: no done, Result keeps last value
    @(negedge clk);
    op = 2'b10; ReadDataA = 16'd100; ReadDataB = 16'd7; fwd_A = '0; fwd_B = '0; start = 1'b1;
    repeat (5) @(negedge clk);
    flush = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_result", 32'(Result), 32'(last_res));
    flush = 1'b0;
    repeat (20) @(negedge clk);
    chk("flush_result_hold", 32'(Result), 32'(last_res));

    // flush together with start in IDLE captures nothing
    @(negedge clk);
    op = 2'b00; start = 1'b1; flush = 1'b1;
    #1 chk("flush_idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1 chk("flush_idle_nocap", 32'(busy), 32'd0);

    // asynchronous reset in the middle of CALC
    @(negedge clk);
    op = 2'b00; ReadDataA = 16'd9; ReadDataB = 16'd9; start = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_result", 32'(Result), 32'd0);
    chk("arst_divzero", 32'(DivZero), 32'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    last_res = '0;
    do_op(2'b00, 16'h0003, 16'h0005, 2'b00, 2'b00, '0, '0, 1'b0);

    repeat (3) @(negedge clk);
    if (sb.size() != 0) chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
